// File: rtl/tof_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tof_pkg : shared sizes and FSM encoding for the ToF readout path
// Rev 1.0 : initial release
// ============================================================================
package tof_pkg;

  localparam int N_SENSORS = 8;
  localparam int DIST_W    = 16;
  localparam int IDX_W     = 6;
  localparam int TOF_REC_W = IDX_W + DIST_W;
  localparam int SEL_W     = $clog2(N_SENSORS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } tof_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request after last_grant
// Rev 1.0 : initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last_grant,
  output logic [W-1:0] o_grant,
  output logic         o_found
);

  logic [W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest request is written last.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int i = N; i >= 1; i--) begin
      w_idx = W'((32'(i_last_grant) + 32'(i)) % 32'(N));
      if (i_req[w_idx]) begin
        o_grant = w_idx;
      end
    end
  end

  assign o_found = |i_req;

endmodule
`default_nettype wire

// File: rtl/tof_readout_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tof_readout_scheduler : round-robin readout of the ToF array onto a stream
// Rev 1.0 : initial release
// ============================================================================
module tof_readout_scheduler
  import tof_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] enable_mask,
  input  logic [N_SENSORS-1:0] ready_in,
  input  logic [TOF_REC_W-1:0] data_in,
  output logic [SEL_W-1:0]     tof_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sensor,
  output logic [IDX_W-1:0]     out_zone,
  output logic [DIST_W-1:0]    out_distance,
  output logic [7:0]           out_seq,
  output logic                 sweep_done,
  output logic                 busy
);

  localparam int               CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  tof_state_e           r_state;
  tof_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_settle_cnt;
  logic [N_SENSORS-1:0] r_pending;
  logic [N_SENSORS-1:0] r_served;
  logic [N_SENSORS-1:0] w_pending_nxt;
  logic [N_SENSORS-1:0] w_ignore;
  logic [N_SENSORS-1:0] w_cap_bit;
  logic [N_SENSORS-1:0] w_req;
  logic [SEL_W-1:0]     r_tof_index;
  logic [SEL_W-1:0]     r_last_grant;
  logic [SEL_W-1:0]     w_grant;
  logic                 w_found;
  logic                 w_do_grant;
  logic                 w_do_capture;
  logic                 w_do_accept;
  logic                 w_sweep;
  logic                 r_out_valid;
  logic [SEL_W-1:0]     r_out_sensor;
  logic [IDX_W-1:0]     r_out_zone;
  logic [DIST_W-1:0]    r_out_distance;
  logic [7:0]           r_out_seq;
  logic                 r_sweep_done;

  assign w_req = r_pending & enable_mask;

  rr_arbiter #(
    .N (N_SENSORS),
    .W (SEL_W)
  ) u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_found      (w_found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_do_grant   = 1'b0;
    w_do_capture = 1'b0;
    w_do_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_do_grant  = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == C_SETTLE_LAST) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_do_capture = 1'b1;
        w_state_nxt  = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (r_out_valid && out_ready) begin
          w_do_accept = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The selected sensor's ready bit is stale until the array has seen the new
  // index, so it is masked from the grant edge through the capture edge.
  always_comb begin
    w_ignore  = '0;
    w_cap_bit = '0;
    if (w_do_grant) begin
      w_ignore[w_grant] = 1'b1;
    end else if (r_state == ST_SETTLE || r_state == ST_CAPTURE) begin
      w_ignore[r_tof_index] = 1'b1;
    end
    if (w_do_capture) begin
      w_cap_bit[r_tof_index] = 1'b1;
    end
    w_pending_nxt = (r_pending | (ready_in & ~w_ignore)) & enable_mask & ~w_cap_bit;
  end

  assign w_sweep = (enable_mask != '0) && ((r_served & enable_mask) == enable_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending      <= '0;
      r_served       <= '0;
      r_tof_index    <= '0;
      r_last_grant   <= SEL_W'(N_SENSORS - 1);
      r_settle_cnt   <= '0;
      r_out_valid    <= 1'b0;
      r_out_sensor   <= '0;
      r_out_zone     <= '0;
      r_out_distance <= '0;
      r_out_seq      <= '0;
      r_sweep_done   <= 1'b0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_sweep_done <= w_sweep;
      r_served     <= w_sweep ? w_cap_bit : (r_served | w_cap_bit);

      if (w_do_grant) begin
        r_tof_index  <= w_grant;
        r_last_grant <= w_grant;
        r_settle_cnt <= '0;
      end else if (r_state == ST_SETTLE && r_settle_cnt != C_SETTLE_LAST) begin
        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
      end

      if (w_do_capture) begin
        r_out_valid    <= 1'b1;
        r_out_sensor   <= r_tof_index;
        r_out_zone     <= data_in[TOF_REC_W-1:DIST_W];
        r_out_distance <= data_in[DIST_W-1:0];
      end else if (w_do_accept) begin
        r_out_valid <= 1'b0;
        r_out_seq   <= r_out_seq + 8'd1;
      end
    end
  end

  assign tof_index    = r_tof_index;
  assign out_valid    = r_out_valid;
  assign out_sensor   = r_out_sensor;
  assign out_zone     = r_out_zone;
  assign out_distance = r_out_distance;
  assign out_seq      = r_out_seq;
  assign sweep_done   = r_sweep_done;
  assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tof_readout_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_tof_readout_scheduler : sensor-array emulation plus transaction-level model
// Rev 1.0 : initial release
// ============================================================================
module tb_tof_readout_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  enable_mask;
  logic [7:0]  ready_in;
  logic [21:0] data_in;
  logic [2:0]  tof_index;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sensor;
  logic [5:0]  out_zone;
  logic [15:0] out_distance;
  logic [7:0]  out_seq;
  logic        sweep_done;
  logic        busy;

  logic [21:0] sens_data [8];

  int nvec, nerr, cyc;
  int sw_cnt, sw_cyc;
  logic [2:0]  got_s [$];
  logic [5:0]  got_z [$];
  logic [15:0] got_d [$];
  logic [7:0]  got_q [$];
  int          rise_cyc [$];

  logic [2:0] m_last;
  logic [7:0] m_seq;
  logic [7:0] m_served;

  always #5 clk = ~clk;

  assign data_in = sens_data[tof_index];

  tof_readout_scheduler #(.SETTLE_CYCLES(1)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable_mask  (enable_mask),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .tof_index    (tof_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sensor   (out_sensor),
    .out_zone     (out_zone),
    .out_distance (out_distance),
    .out_seq      (out_seq),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );

  task automatic clear_mon();
    got_s.delete(); got_z.delete(); got_d.delete(); got_q.delete();
    rise_cyc.delete();
    sw_cnt = 0;
    sw_cyc = -1;
  endtask

  // One clock; emulates the array clearing the indexed ready bit and logs traffic.
  task automatic tick();
    logic [2:0] idx, s;
    logic [5:0] z;
    logic [15:0] d;
    logic [7:0] q;
    logic acc, pv;
    idx = tof_index; acc = out_valid & out_ready; pv = out_valid;
    s = out_sensor; z = out_zone; d = out_distance; q = out_seq;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      got_s.push_back(s); got_z.push_back(z); got_d.push_back(d); got_q.push_back(q);
    end
    ready_in[idx] = 1'b0;
    if (sweep_done) begin
      sw_cnt++;
      sw_cyc = cyc;
    end
    if (out_valid && !pv) rise_cyc.push_back(cyc);
  endtask

  task automatic wait_records(input int n, input int max_cyc, input bit rand_ready, output bit ok);
    int c = 0;
    while (got_s.size() < n && c < max_cyc) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    ok = (got_s.size() >= n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable_mask = '0; ready_in = '0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) sens_data[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    m_last = 3'd7; m_seq = 8'd0; m_served = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({tof_index, out_valid, out_sensor, out_zone, out_distance, out_seq, sweep_done, busy} !== 37'd0) begin
      nerr++;
      $display("FAIL reset_values: got idx=%0d v=%0b s=%0d z=%h d=%h q=%0d sw=%0b busy=%0b, want all zero",
               tof_index, out_valid, out_sensor, out_zone, out_distance, out_seq, sweep_done, busy);
    end
  endtask

  task automatic test_basic();
    enable_mask = 8'hFF; out_ready = 1'b1;
    sens_data[2] = 22'h0A1234;
    ready_in = 8'b0000_0100;
    tick();
    tick();
    nvec++;
    if (tof_index !== 3'd2 || busy !== 1'b1) begin
      nerr++; $display("FAIL basic_select: got idx=%0d busy=%0b want idx=2 busy=1", tof_index, busy);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL basic_early_valid: got %0b want 0", out_valid);
    end
    tick();
    nvec++;
    if ({out_valid, out_sensor, out_zone, out_distance, out_seq} !== {1'b1, 3'd2, 6'h0A, 16'h1234, 8'd0}) begin
      nerr++;
      $display("FAIL basic_record: got v=%0b s=%0d z=%h d=%h q=%0d want v=1 s=2 z=0a d=1234 q=0",
               out_valid, out_sensor, out_zone, out_distance, out_seq);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_seq !== 8'd1) begin
      nerr++; $display("FAIL basic_accept: got v=%0b q=%0d want v=0 q=1", out_valid, out_seq);
    end
  endtask

  task automatic test_sweep_all();
    bit ok;
    do_reset();
    enable_mask = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) sens_data[k] = 22'($urandom);
    ready_in = 8'hFF;
    wait_records(8, 200, 1'b0, ok);
    repeat (3) tick();
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL sweep_count: got %0d records want 8", got_s.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        nvec++;
        if (got_s[i] !== 3'(i) || {got_z[i], got_d[i]} !== sens_data[i] || got_q[i] !== 8'(i)) begin
          nerr++;
          $display("FAIL sweep_rec%0d: got s=%0d rec=%h q=%0d want s=%0d rec=%h q=%0d",
                   i, got_s[i], {got_z[i], got_d[i]}, got_q[i], i, sens_data[i], i);
        end
      end
    end
    nvec++;
    if (sw_cnt !== 1) begin
      nerr++; $display("FAIL sweep_pulses: got %0d want 1", sw_cnt);
    end
    nvec++;
    if (rise_cyc.size() != 8 || sw_cyc != rise_cyc[rise_cyc.size()-1] + 1) begin
      nerr++; $display("FAIL sweep_timing: got pulse cycle %0d, %0d valid rises, want 8 rises and pulse one after last",
                       sw_cyc, rise_cyc.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        nvec++;
        if (rise_cyc[i+1] - rise_cyc[i] != 4) begin
          nerr++; $display("FAIL sweep_spacing%0d: got %0d want 4", i, rise_cyc[i+1] - rise_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_parked_pulse();
    bit ok;
    clear_mon();
    sens_data[5] = 22'($urandom);
    ready_in[5] = 1'b1;
    wait_records(1, 50, 1'b0, ok);
    repeat (3) tick();
    nvec++;
    if (!ok || tof_index !== 3'd5) begin
      nerr++; $display("FAIL parked_setup: got idx=%0d ok=%0b want idx=5", tof_index, ok);
    end
    clear_mon();
    sens_data[5] = 22'($urandom);
    ready_in[5] = 1'b1;
    wait_records(1, 50, 1'b0, ok);
    nvec++;
    if (!ok || got_s[0] !== 3'd5 || {got_z[0], got_d[0]} !== sens_data[5]) begin
      nerr++; $display("FAIL parked_pulse: got %0d records, first s=%0d rec=%h want s=5 rec=%h",
                       got_s.size(), ok ? got_s[0] : 3'd0, ok ? {got_z[0], got_d[0]} : 22'd0, sens_data[5]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c = 0;
    logic [36:0] snap;
    clear_mon();
    out_ready = 1'b0;
    sens_data[3] = 22'($urandom);
    ready_in[3] = 1'b1;
    while (!out_valid && c < 20) begin tick(); c++; end
    nvec++;
    if (!out_valid) begin
      nerr++; $display("FAIL bp_valid_timeout: got out_valid=0 want 1");
    end
    snap = {out_valid, out_sensor, out_zone, out_distance, out_seq, tof_index};
    sens_data[6] = 22'($urandom);
    ready_in[6] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++;
      if ({out_valid, out_sensor, out_zone, out_distance, out_seq, tof_index} !== snap) begin
        nerr++; $display("FAIL bp_hold%0d: got %h want %h", i,
                         {out_valid, out_sensor, out_zone, out_distance, out_seq, tof_index}, snap);
      end
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || tof_index !== 3'd3) begin
      nerr++; $display("FAIL bp_release: got v=%0b idx=%0d want v=0 idx=3", out_valid, tof_index);
    end
    tick();
    nvec++;
    if (tof_index !== 3'd6) begin
      nerr++; $display("FAIL bp_next_grant: got idx=%0d want 6", tof_index);
    end
    wait_records(2, 50, 1'b0, ok);
    nvec++;
    if (!ok || got_s[0] !== 3'd3 || got_s[1] !== 3'd6 || {got_z[0], got_d[0]} !== sens_data[3]) begin
      nerr++; $display("FAIL bp_order: got %0d records want sensors 3 then 6", got_s.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] e, r;
    logic [2:0] exp_s [$];
    int exp_sw, k;
    do_reset();
    for (int b = 0; b < 25; b++) begin
      clear_mon();
      exp_s.delete();
      exp_sw = 0;
      e = 8'($urandom_range(1, 255));
      enable_mask = e;
      if ((m_served & e) == e) begin exp_sw++; m_served = 8'd0; end
      out_ready = 1'b1;
      tick(); tick();
      r = 8'($urandom) & e;
      for (int j = 0; j < 8; j++) if (r[j]) sens_data[j] = 22'($urandom);
      ready_in = ready_in | r;
      for (int i = 1; i <= 8; i++) begin
        k = (int'(m_last) + i) % 8;
        if (r[k]) begin
          exp_s.push_back(3'(k));
          m_served[k] = 1'b1;
          if ((m_served & e) == e) begin exp_sw++; m_served = 8'd0; end
        end
      end
      if (exp_s.size() > 0) m_last = exp_s[exp_s.size()-1];
      wait_records(exp_s.size(), 600, 1'b1, ok);
      out_ready = 1'b1;
      repeat (4) tick();
      nvec++;
      if (!ok || got_s.size() != exp_s.size()) begin
        nerr++; $display("FAIL rand_b%0d_count: got %0d records want %0d", b, got_s.size(), exp_s.size());
      end else begin
        for (int i = 0; i < exp_s.size(); i++) begin
          nvec++;
          if (got_s[i] !== exp_s[i] || {got_z[i], got_d[i]} !== sens_data[exp_s[i]] || got_q[i] !== m_seq) begin
            nerr++;
            $display("FAIL rand_b%0d_rec%0d: got s=%0d rec=%h q=%0d want s=%0d rec=%h q=%0d", b, i,
                     got_s[i], {got_z[i], got_d[i]}, got_q[i], exp_s[i], sens_data[exp_s[i]], m_seq);
          end
          m_seq = m_seq + 8'd1;
        end
      end
      nvec++;
      if (sw_cnt != exp_sw) begin
        nerr++; $display("FAIL rand_b%0d_sweep: got %0d pulses want %0d", b, sw_cnt, exp_sw);
      end
    end
  endtask

  task automatic test_enable_subset();
    bit ok;
    do_reset();
    enable_mask = 8'b0000_0011; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) sens_data[k] = 22'($urandom);
    ready_in = 8'hFF;
    wait_records(2, 50, 1'b0, ok);
    repeat (30) tick();
    nvec++;
    if (!ok || got_s.size() != 2 || got_s[0] !== 3'd0 || got_s[1] !== 3'd1) begin
      nerr++; $display("FAIL subset_records: got %0d records want exactly sensors 0,1", got_s.size());
    end
    nvec++;
    if (sw_cnt != 1 || busy !== 1'b0) begin
      nerr++; $display("FAIL subset_sweep: got pulses=%0d busy=%0b want pulses=1 busy=0", sw_cnt, busy);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int c = 0;
    ready_in = '0;
    enable_mask = 8'hFF; out_ready = 1'b0;
    sens_data[4] = 22'($urandom);
    ready_in[4] = 1'b1;
    while (!out_valid && c < 20) begin tick(); c++; end
    nvec++;
    if (!out_valid || out_seq === 8'd0) begin
      nerr++; $display("FAIL rst_setup: got v=%0b q=%0d want v=1 q!=0", out_valid, out_seq);
    end
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, out_seq, tof_index, busy} !== 13'd0) begin
      nerr++; $display("FAIL rst_async: got v=%0b q=%0d idx=%0d busy=%0b want all 0",
                       out_valid, out_seq, tof_index, busy);
    end
    ready_in = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    out_ready = 1'b1;
    sens_data[0] = 22'($urandom);
    ready_in = 8'h11;
    wait_records(2, 50, 1'b0, ok);
    nvec++;
    if (!ok || got_s[0] !== 3'd0 || got_s[1] !== 3'd4 || got_q[0] !== 8'd0) begin
      nerr++; $display("FAIL rst_restart: got %0d records first s=%0d q=%0d want s=0 then 4, q=0",
                       got_s.size(), ok ? got_s[0] : 3'd0, ok ? got_q[0] : 8'd0);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    test_reset();
    test_basic();
    test_sweep_all();
    test_parked_pulse();
    test_backpressure();
    test_random();
    test_enable_subset();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
